// File: rtl/dict_create_pkg.sv
// Shared types and constants for the dictionary header writer.
// The header is two link bytes, one length byte, then the name.
package dict_create_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LF0,
        LF1,
        LEN,
        RD,
        WR,
        DONE
    } create_sts;

    localparam int NAME_MAX = 31;
    localparam int HDR_SZ   = 3;

endpackage

// File: rtl/dict_create.sv
// Dictionary header writer: links a new header to LAST, writes the length
// and copies the name out of the TIB, then advances HERE and LAST.
module dict_create
    import dict_create_pkg::*;
#(
    parameter int             ASZ      = 16,
    parameter logic [ASZ-1:0] HERE0    = 16'h0100,
    parameter logic [ASZ-1:0] DICT_END = 16'hF000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [ASZ-1:0] tib,
    input  logic [7:0]     len,
    input  logic [7:0]     mem_din,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_we,
    output logic [7:0]     mem_dout,
    output logic           bsy,
    output logic           done,
    output logic           err,
    output logic [ASZ-1:0] here,
    output logic [ASZ-1:0] last
);

    create_sts      state_q, state_d;
    logic [ASZ-1:0] tib_q,   tib_d;
    logic [4:0]     len_q,   len_d;
    logic [ASZ-1:0] base_q,  base_d;
    logic [4:0]     i_q,     i_d;
    logic [ASZ-1:0] here_q,  here_d;
    logic [ASZ-1:0] last_q,  last_d;
    logic           err_q,   err_d;

    logic           len_ok;
    logic           fits;
    logic [ASZ:0]   new_end;
    logic [ASZ-1:0] name_end;
    logic [15:0]    link16;

    // One extra bit keeps a HERE near the top of memory from wrapping past the check.
    assign new_end  = {1'b0, here_q} + (ASZ+1)'(HDR_SZ) + {{(ASZ-7){1'b0}}, len};
    assign fits     = new_end <= {1'b0, DICT_END};
    assign len_ok   = (len != 8'd0) && (len <= 8'(NAME_MAX));
    assign name_end = base_q + ASZ'(HDR_SZ) + ASZ'(len_q);
    assign link16   = 16'(last_q);

    always_comb begin
        state_d = state_q;
        tib_d   = tib_q;
        len_d   = len_q;
        base_d  = base_q;
        i_d     = i_q;
        here_d  = here_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok && fits) begin
                        tib_d   = tib;
                        len_d   = len[4:0];
                        base_d  = here_q;
                        i_d     = 5'd0;
                        state_d = LF0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LF0: state_d = LF1;
            LF1: state_d = LEN;
            LEN: state_d = RD;
            RD:  state_d = WR;
            WR: begin
                if (i_q == len_q - 5'd1) begin
                    state_d = DONE;
                    last_d  = base_q;
                    here_d  = name_end;
                end else begin
                    i_d     = i_q + 5'd1;
                    state_d = RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tib_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            i_q     <= '0;
            here_q  <= HERE0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tib_q   <= tib_d;
            len_q   <= len_d;
            base_q  <= base_d;
            i_q     <= i_d;
            here_q  <= here_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Memory port is a pure decode of the registered state so the arbiter sees it glitch-free.
    always_comb begin
        mem_a    = '0;
        mem_we   = 1'b0;
        mem_dout = 8'h00;
        case (state_q)
            LF0: begin
                mem_a    = base_q;
                mem_we   = 1'b1;
                mem_dout = link16[7:0];
            end
            LF1: begin
                mem_a    = base_q + ASZ'(1);
                mem_we   = 1'b1;
                mem_dout = link16[15:8];
            end
            LEN: begin
                mem_a    = base_q + ASZ'(2);
                mem_we   = 1'b1;
                mem_dout = {3'b000, len_q};
            end
            RD: begin
                mem_a = tib_q + ASZ'(i_q);
            end
            WR: begin
                mem_a    = base_q + ASZ'(HDR_SZ) + ASZ'(i_q);
                mem_we   = 1'b1;
                mem_dout = mem_din;
            end
            default: begin
                mem_a    = '0;
                mem_we   = 1'b0;
                mem_dout = 8'h00;
            end
        endcase
    end

    assign bsy  = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = err_q;
    assign here = here_q;
    assign last = last_q;

endmodule

// File: tb/tb_dict_create.sv
// Directed bench for dict_create: header contents, timing, rejections,
// start-while-busy and asynchronous reset.
module tb_dict_create;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] tib;
    logic [7:0]  len;
    logic [7:0]  mem_din;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        bsy, done, err;
    logic [15:0] here, last;

    // Second instance starts near the end of the dictionary.
    logic        start2;
    logic [7:0]  len2;
    logic [7:0]  mem_din2;
    logic [15:0] mem_a2;
    logic        mem_we2;
    logic [7:0]  mem_dout2;
    logic        bsy2, done2, err2;
    logic [15:0] here2, last2;

    // Third instance starts where a narrow overflow check would wrap.
    logic        start3;
    logic [7:0]  len3;
    logic [15:0] mem_a3;
    logic        mem_we3;
    logic [7:0]  mem_dout3;
    logic        bsy3, done3, err3;
    logic [15:0] here3, last3;

    int vec_cnt = 0;
    int err_cnt = 0;
    int we2_cnt = 0;
    int we3_cnt = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  tib_rom [0:255];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [15:0] ex_a[$];
    logic [7:0]  ex_d[$];

    always #5 clk = ~clk;

    dict_create dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tib(tib), .len(len),
        .mem_din(mem_din), .mem_a(mem_a), .mem_we(mem_we), .mem_dout(mem_dout),
        .bsy(bsy), .done(done), .err(err), .here(here), .last(last)
    );

    dict_create #(.ASZ(16), .HERE0(16'hEFF0), .DICT_END(16'hF000)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .tib(16'h0020), .len(len2),
        .mem_din(mem_din2), .mem_a(mem_a2), .mem_we(mem_we2), .mem_dout(mem_dout2),
        .bsy(bsy2), .done(done2), .err(err2), .here(here2), .last(last2)
    );

    dict_create #(.ASZ(16), .HERE0(16'hFFF0), .DICT_END(16'hF000)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .tib(16'h0020), .len(len3),
        .mem_din(8'h00), .mem_a(mem_a3), .mem_we(mem_we3), .mem_dout(mem_dout3),
        .bsy(bsy3), .done(done3), .err(err3), .here(here3), .last(last3)
    );

    // Pool memory model: TIB region below 0x0100 is a ROM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a] <= mem_dout;
            wa_q.push_back(mem_a);
            wd_q.push_back(mem_dout);
        end
        mem_din <= (mem_a < 16'h0100) ? tib_rom[mem_a[7:0]] : mem[mem_a];
    end

    always @(posedge clk) begin
        if (mem_we2) we2_cnt <= we2_cnt + 1;
        if (mem_we3) we3_cnt <= we3_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        ex_a.push_back(a);
        ex_d.push_back(d);
    endtask

    task automatic chk_log(input string tag);
        int n;
        chk({tag, "_nwr"}, wa_q.size(), ex_a.size());
        n = (wa_q.size() < ex_a.size()) ? wa_q.size() : ex_a.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_a%0d", tag, k), wa_q[k], ex_a[k]);
            chk($sformatf("%s_d%0d", tag, k), wd_q[k], ex_d[k]);
        end
        wa_q.delete(); wd_q.delete(); ex_a.delete(); ex_d.delete();
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] eh, input logic [15:0] el);
        chk({tag, "_bsy"}, bsy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_a"}, mem_a, 16'h0000);
        chk({tag, "_dout"}, mem_dout, 8'h00);
        chk({tag, "_here"}, here, eh);
        chk({tag, "_last"}, last, el);
    endtask

    // Accepted build: checks done cycle, busy length and the idle cycle after.
    task automatic run_build(input string tag, input logic [15:0] t, input logic [7:0] l,
                             input logic [15:0] eh, input logic [15:0] el);
        int cyc;
        int busy;
        @(negedge clk);
        tib = t; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; busy = 0;
        while (!done && cyc < 200) begin
            if (bsy) busy++;
            @(negedge clk);
            cyc++;
        end
        if (bsy) busy++;
        chk({tag, "_done_cyc"}, cyc, 4 + 2 * l);
        chk({tag, "_bsy_len"}, busy, 4 + 2 * l);
        chk({tag, "_here"}, here, eh);
        chk({tag, "_last"}, last, el);
        @(negedge clk);
        chk({tag, "_idle_bsy"}, bsy, 1'b0);
        chk({tag, "_idle_done"}, done, 1'b0);
    endtask

    task automatic run_reject(input string tag, input logic [7:0] l,
                              input logic [15:0] eh, input logic [15:0] el);
        @(negedge clk);
        tib = 16'h0020; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_err1"}, err, 1'b1);
        chk({tag, "_bsy1"}, bsy, 1'b0);
        chk({tag, "_we1"}, mem_we, 1'b0);
        @(negedge clk);
        chk({tag, "_err2"}, err, 1'b0);
        chk({tag, "_here"}, here, eh);
        chk({tag, "_last"}, last, el);
        chk_log(tag);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 256; k++) tib_rom[k] = 8'h00;
        tib_rom[8'h20] = "D"; tib_rom[8'h21] = "U"; tib_rom[8'h22] = "P";
        tib_rom[8'h30] = "X";
        tib_rom[8'h40] = "A"; tib_rom[8'h41] = "B"; tib_rom[8'h42] = "C";
        tib_rom[8'h43] = "D"; tib_rom[8'h44] = "E";
        mem_din2 = 8'hA5;
        rst_n = 1'b0; start = 1'b0; tib = '0; len = '0;
        start2 = 1'b0; len2 = '0; start3 = 1'b0; len3 = '0;

        // Reset values, both during and after reset.
        repeat (2) @(negedge clk);
        chk_idle("rst_hold", 16'h0100, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("rst_rel", 16'h0100, 16'h0000);

        // First word "DUP".
        exp_wr(16'h0100, 8'h00); exp_wr(16'h0101, 8'h00); exp_wr(16'h0102, 8'h03);
        exp_wr(16'h0103, "D");   exp_wr(16'h0104, "U");   exp_wr(16'h0105, "P");
        run_build("dup", 16'h0020, 8'd3, 16'h0106, 16'h0100);
        chk_log("dup");

        // Second word "X" links back to DUP.
        exp_wr(16'h0106, 8'h00); exp_wr(16'h0107, 8'h01); exp_wr(16'h0108, 8'h01);
        exp_wr(16'h0109, "X");
        run_build("x", 16'h0030, 8'd1, 16'h010A, 16'h0106);
        chk_log("x");

        // Bad lengths.
        run_reject("len0", 8'd0, 16'h010A, 16'h0106);
        run_reject("len32", 8'd32, 16'h010A, 16'h0106);
        run_reject("len200", 8'd200, 16'h010A, 16'h0106);

        // Start held high through a len=5 build, restarting in the first IDLE cycle.
        exp_wr(16'h010A, 8'h06); exp_wr(16'h010B, 8'h01); exp_wr(16'h010C, 8'h05);
        exp_wr(16'h010D, "A"); exp_wr(16'h010E, "B"); exp_wr(16'h010F, "C");
        exp_wr(16'h0110, "D"); exp_wr(16'h0111, "E");
        exp_wr(16'h0112, 8'h0A); exp_wr(16'h0113, 8'h01); exp_wr(16'h0114, 8'h05);
        exp_wr(16'h0115, "A"); exp_wr(16'h0116, "B"); exp_wr(16'h0117, "C");
        exp_wr(16'h0118, "D"); exp_wr(16'h0119, "E");
        @(negedge clk);
        tib = 16'h0040; len = 8'd5; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_done1_cyc", cyc, 14);
        chk("hold_here1", here, 16'h0112);
        chk("hold_last1", last, 16'h010A);
        @(negedge clk);
        chk("hold_idle_bsy", bsy, 1'b0);
        @(negedge clk);
        chk("hold_restart_bsy", bsy, 1'b1);
        start = 1'b0;
        cyc = 16;
        while (!done && cyc < 250) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_done2_cyc", cyc, 29);
        chk("hold_here2", here, 16'h011A);
        chk("hold_last2", last, 16'h0112);
        @(negedge clk);
        chk("hold_end_bsy", bsy, 1'b0);
        chk_log("hold");

        // Asynchronous reset in cycle 6 of a build.
        @(negedge clk);
        tib = 16'h0020; len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst6_bsy_before", bsy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle("rst6", 16'h0100, 16'h0000);
        wa_q.delete(); wd_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst6_after", 16'h0100, 16'h0000);
        chk_log("rst6_quiet");

        // Overflow from here=EFF0: len=31 rejected, len=13 exactly reaches DICT_END.
        we2_cnt = 0;
        @(negedge clk);
        len2 = 8'd31; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("ovf31_err", err2, 1'b1);
        chk("ovf31_bsy", bsy2, 1'b0);
        @(negedge clk);
        chk("ovf31_here", here2, 16'hEFF0);
        chk("ovf31_nwr", we2_cnt, 0);
        len2 = 8'd13; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("fit13_err", err2, 1'b0);
        chk("fit13_bsy", bsy2, 1'b1);
        cyc = 1;
        while (!done2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("fit13_done_cyc", cyc, 30);
        chk("fit13_here", here2, 16'hF000);
        chk("fit13_last", last2, 16'hEFF0);
        @(negedge clk);
        chk("fit13_nwr", we2_cnt, 16);
        len2 = 8'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("full_err", err2, 1'b1);
        chk("full_bsy", bsy2, 1'b0);

        // here=FFF0 must not wrap past the end check.
        @(negedge clk);
        len3 = 8'd31; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("wrap_err", err3, 1'b1);
        chk("wrap_bsy", bsy3, 1'b0);
        repeat (2) @(negedge clk);
        chk("wrap_nwr", we3_cnt, 0);
        chk("wrap_here", here3, 16'hFFF0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dict_create.md
# dict_create

Dictionary header writer for the ForthSuper pool memory: the writing counterpart of the pool's FIND search. On a start pulse it builds a new word header at HERE: two link bytes pointing at the previous header, a length byte, then the name copied byte by byte from the TIB. It then advances HERE and LAST so that a later FIND walks the new word first. It sits between the outer interpreter (CREATE / `:`) and the byte-wide pool memory port.

## Interface
Parameters:
- ASZ, 16, byte address width of pool memory.
- HERE0, 16'h0100, HERE value after reset.
- DICT_END, 16'hF000, first address the dictionary must not reach.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- tib  in  ASZ  address of first name character in TIB; sampled with start.
- len  in  8  name length; valid range 1..31; sampled with start.
- mem_din  in  8  pool read data; 1-cycle read latency.
- mem_a  out  ASZ  pool address.
- mem_we  out  1  pool write enable.
- mem_dout  out  8  pool write data.
- bsy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle rejection pulse.
- here  out  ASZ  next free dictionary byte.
- last  out  ASZ  address of newest header (its LF0 byte); 0 = empty dictionary.

## Operation
- States: IDLE, LF0, LF1, LEN, RD, WR, DONE.
- IDLE: start=1 with len in 1..31 and here+3+len <= DICT_END: latch tib, len and base=here, clear index i, go to LF0. Otherwise, with start=1: pulse err, make no write, stay IDLE.
- LF0: write last[7:0] to base+0.
- LF1: write last[15:8] to base+1.
- LEN: write {3'b000, len[4:0]} to base+2.
- RD: mem_a=tib+i, mem_we=0.
- WR: mem_a=base+3+i, mem_we=1, mem_dout=mem_din. Name bytes are copied unmodified.
- WR with i==len-1 goes to DONE; otherwise i++ and return to RD.
- On the WR->DONE transition: last<=base, here<=base+3+len.
- DONE: done=1, then go to IDLE.
- mem_a, mem_we and mem_dout are decoded from state, base and i. In IDLE and DONE all three are 0.
- start while bsy is ignored. It is not queued.
- Address arithmetic is ASZ bits wide. The overflow check uses a compare at ASZ+1 bits, so here near 2^ASZ cannot wrap.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1, 2, 3: LF0, LF1 and LEN writes.
- Cycle 4+2j: RD for name byte j.
- Cycle 5+2j: WR for name byte j.
- Cycle 4+2·len: DONE, done=1. here and last already show their new values in this cycle.
- Cycle 5+2·len: IDLE; a new start is accepted in this cycle.
- bsy is high for exactly 4+2·len cycles.
- Rejection: err=1 in cycle 1, bsy stays 0, mem_we stays 0 throughout.
- Reset values: state IDLE, bsy=0, done=0, err=0, mem_we=0, mem_a=0, mem_dout=0, here=HERE0, last=0.
- Reset mid-operation: return to the reset values immediately. Any partially written header bytes stay in memory but are unreachable, because last and here are not updated.

## Structure
- FS1 package additions:
  - `create_sts` enum (IDLE..DONE, 3 bits, automatic encoding as for pool_sts).
  - NAME_MAX = 31.
  - HDR_SZ = 3.
- One module, no sub-module. The pool arbiter muxes this block's memory port against the FIND engine using bsy.

## Test plan
- Reset, no stimulus -> here=16'h0100, last=0, all other outputs 0.
- First word: start, tib=16'h0020, len=3, TIB="DUP".
  - Memory writes in order: 0100<=00, 0101<=00, 0102<=03, 0103<='D', 0104<='U', 0105<='P'.
  - done in cycle 10; here=16'h0106, last=16'h0100.
- Second word: start, len=1, TIB="X".
  - Writes: 0106<=00, 0107<=01, 0108<=01, 0109<='X'.
  - last=16'h0106, here=16'h010A.
- Bad length: start with len=0, then start with len=32 -> each gives one err pulse, no mem_we, here and last unchanged.
- Overflow: here=16'hEFF0, start with len=31 -> err, no writes.
- Control corner cases:
  - start held high during a len=5 build -> exactly one header written; a second build starts in the IDLE cycle after done.
  - rst_n asserted in cycle 6 -> outputs return to reset values immediately.
